// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer and the array controller:
// opcode values, instruction field positions and the issuer FSM encoding.
package instr_issuer_pkg;

    // Instruction field layout; bits above the data field are always zero.
    localparam int OP_LSB       = 0;
    localparam int OP_W         = 5;
    localparam int ADDR_LSB     = 5;
    localparam int ADDR_W       = 6;
    localparam int DATA_LSB     = 11;
    localparam int FIELD_DATA_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_NOP        = 5'b00000,
        OP_COMPUTE    = 5'b00001,
        OP_COMPUTE_IM = 5'b00010,
        OP_ACC2OB     = 5'b00011,
        OP_INP_WR     = 5'b00100,
        OP_WT_WR      = 5'b00101,
        OP_OB_SEND    = 5'b00110,
        OP_ACC_RST    = 5'b00111
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACC_RST = 3'd1,
        ST_LD_INP  = 3'd2,
        ST_LD_WT   = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_SEND    = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    // First non-empty phase of a run; pass zero for phases already finished.
    function automatic state_t first_phase(input logic [6:0] n_inp,
                                           input logic [6:0] n_wt,
                                           input logic [7:0] len);
        if (n_inp != 7'd0)      return ST_LD_INP;
        else if (n_wt != 7'd0)  return ST_LD_WT;
        else if (len != 8'd0)   return ST_COMPUTE;
        return ST_DRAIN;
    endfunction

endpackage

// File: rtl/instr_issuer_pack.sv
// Combinational packer: places opcode, address and data into the instruction word.
module instr_pack
    import instr_issuer_pkg::*;
#(
    parameter int INSTR_W = 64
) (
    input  opcode_t                   opcode,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [FIELD_DATA_W-1:0]   data,
    output logic [INSTR_W-1:0]        word
);

    // Zero-fill, then drop each field into its slot.
    always_comb begin
        word = '0;
        word[OP_LSB   +: OP_W]         = opcode;
        word[ADDR_LSB +: ADDR_W]       = addr;
        word[DATA_LSB +: FIELD_DATA_W] = data;
    end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: sequences accumulator reset, input/weight loads from the
// host, compute, drain and send into a registered instruction stream.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int INSTR_W = 64,
    parameter int DATA_W  = 32,
    parameter int NUM_ACC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               i_mode_req,
    input  logic [6:0]         n_inp,
    input  logic [6:0]         n_wt,
    input  logic [7:0]         compute_len,
    input  logic               abort,
    input  logic               host_valid,
    input  logic [DATA_W-1:0]  host_data,
    output logic               host_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               done
);

    localparam logic [6:0] LAST_ACC = 7'(NUM_ACC - 1);

    state_t              state;
    logic [6:0]          n_inp_q;
    logic [6:0]          n_wt_q;
    logic [7:0]          len_q;
    logic                i_mode_q;
    logic [6:0]          ld_cnt;
    logic [7:0]          cmp_cnt;

    opcode_t             act_op;
    logic [ADDR_W-1:0]   act_addr;
    logic [DATA_W-1:0]   act_data;
    logic [INSTR_W-1:0]  act_word;

    // Host handshake is open only in the load states and drops at once on abort.
    assign host_ready = (state == ST_LD_INP || state == ST_LD_WT) && !abort;
    assign busy       = (state != ST_IDLE);

    // Decode the action this cycle will issue; abort turns it into a NOP.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        act_op   = OP_NOP;
        act_addr = '0;
        act_data = '0;
        if (!abort) begin
            case (state)
                ST_ACC_RST: act_op = OP_ACC_RST;
                ST_LD_INP, ST_LD_WT: begin
                    if (host_valid) begin
                        act_op   = (state == ST_LD_INP) ? OP_INP_WR : OP_WT_WR;
                        act_addr = ld_cnt[ADDR_W-1:0];
                        act_data = host_data;
                    end
                end
                ST_COMPUTE: act_op = i_mode_q ? OP_COMPUTE_IM : OP_COMPUTE;
                ST_DRAIN: begin
                    act_op   = OP_ACC2OB;
                    act_addr = ld_cnt[ADDR_W-1:0];
                end
                ST_SEND: begin
                    act_op   = OP_OB_SEND;
                    act_addr = ld_cnt[ADDR_W-1:0];
                end
                default: act_op = OP_NOP;
            endcase
        end
    end

    instr_pack #(.INSTR_W(INSTR_W)) u_pack (
        .opcode (act_op),
        .addr   (act_addr),
        .data   (act_data),
        .word   (act_word)
    );

    // Run FSM: advances phases, steps counters and registers the issued word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            n_inp_q     <= '0;
            n_wt_q      <= '0;
            len_q       <= '0;
            i_mode_q    <= 1'b0;
            ld_cnt      <= '0;
            cmp_cnt     <= '0;
            instruction <= '0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done        <= 1'b0;
            instruction <= act_word;
            if (state != ST_IDLE && abort) begin
                state   <= ST_IDLE;
                ld_cnt  <= '0;
                cmp_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            n_inp_q  <= n_inp;
                            n_wt_q   <= n_wt;
                            len_q    <= compute_len;
                            i_mode_q <= i_mode_req;
                            state    <= ST_ACC_RST;
                        end
                    end
                    ST_ACC_RST: state <= first_phase(n_inp_q, n_wt_q, len_q);
                    ST_LD_INP: begin
                        if (host_valid) begin
                            if (ld_cnt == n_inp_q - 7'd1) begin
                                ld_cnt <= '0;
                                state  <= first_phase(7'd0, n_wt_q, len_q);
                            end else begin
                                ld_cnt <= ld_cnt + 7'd1;
                            end
                        end
                    end
                    ST_LD_WT: begin
                        if (host_valid) begin
                            if (ld_cnt == n_wt_q - 7'd1) begin
                                ld_cnt <= '0;
                                state  <= first_phase(7'd0, 7'd0, len_q);
                            end else begin
                                ld_cnt <= ld_cnt + 7'd1;
                            end
                        end
                    end
                    ST_COMPUTE: begin
                        if (cmp_cnt == len_q - 8'd1) begin
                            cmp_cnt <= '0;
                            state   <= ST_DRAIN;
                        end else begin
                            cmp_cnt <= cmp_cnt + 8'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (ld_cnt == LAST_ACC) begin
                            ld_cnt <= '0;
                            state  <= ST_SEND;
                        end else begin
                            ld_cnt <= ld_cnt + 7'd1;
                        end
                    end
                    ST_SEND: begin
                        if (ld_cnt == LAST_ACC) begin
                            ld_cnt <= '0;
                            state  <= ST_FIN;
                        end else begin
                            ld_cnt <= ld_cnt + 7'd1;
                        end
                    end
                    ST_FIN: begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Parameter: INSTR_W, 64, instruction word width.
REQ-002 Parameter: DATA_W, 32, payload width carried in instruction bits [42:11].
REQ-003 Parameter: NUM_ACC, 16, accumulator/output-buffer entries drained per run.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset; asynchronous and active-low.
REQ-006 Port: start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 Port: i_mode_req  input  1  compute flavour; 0 selects opcode 00001, 1 selects opcode 00010.
REQ-008 Port: n_inp  input  7  input words to load (0..64); latched on accepted start.
REQ-009 Port: n_wt  input  7  weight words to load (0..64); latched on accepted start.
REQ-010 Port: compute_len  input  8  compute-instruction cycles (0..255); latched on accepted start.
REQ-011 Port: abort  input  1  synchronous cancel of the current run.
REQ-012 Port: host_valid  input  1  host_data holds a valid load word.
REQ-013 Port: host_data  input  32  load payload.
REQ-014 Port: host_ready  output  1  issuer accepts host_data this cycle.
REQ-015 Port: instruction  output  64  registered instruction word to the array controller.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse when a run completes normally.

Function
REQ-018 Instruction encoding: bits [4:0] opcode, bits [10:5] address, bits [42:11] data, bits [63:43] zero; unused fields zero.
REQ-019 Opcodes: 00000 NOP, 00001 compute, 00010 compute i_mode, 00011 acc-to-outbuf, 00100 input write, 00101 weight write, 00110 outbuf send, 00111 accum reset.
REQ-020 instruction is registered; each FSM action appears on instruction one cycle after the edge that decides it; NOP otherwise.
REQ-021 FSM states: IDLE, ACC_RST, LD_INP, LD_WT, COMPUTE, DRAIN, SEND, FIN.
REQ-022 IDLE: start=1 latches the run inputs and moves to ACC_RST; start in any other state is ignored.
REQ-023 ACC_RST: issues one 00111 instruction, then moves to LD_INP.
REQ-024 LD_INP: host_ready=1; each valid&ready transfer issues 00100 with address = word index (0,1,...) and data = host_data; no transfer issues NOP and holds the index.
REQ-025 LD_INP exits to LD_WT after transfer index n_inp-1; n_inp=0 skips LD_INP with zero cycles spent.
REQ-026 LD_WT: identical to LD_INP using opcode 00101 and n_wt; exits to COMPUTE.
REQ-027 host_ready=0 in every state other than LD_INP and LD_WT.
REQ-028 COMPUTE: issues 00001 (i_mode_req latched 0) or 00010 (latched 1) for exactly compute_len consecutive cycles; compute_len=0 skips.
REQ-029 DRAIN: issues 00011 with address 0..NUM_ACC-1, one per cycle; then SEND.
REQ-030 SEND: issues 00110 with address 0..NUM_ACC-1, one per cycle; then FIN.
REQ-031 FIN: done=1 for one cycle, instruction NOP, return to IDLE.
REQ-032 Counters are 7-bit (load) and 8-bit (compute); no wrap-around occurs within a run.
REQ-033 abort=1 in any non-IDLE state: next instruction NOP, host_ready deasserts the same cycle, FSM to IDLE, no done; abort wins over a simultaneous host transfer (the word is not consumed).
REQ-034 abort in IDLE has no effect; abort and start together in IDLE: abort wins, start ignored.

Reset
REQ-035 rst=0 asynchronously forces IDLE, all counters and latched inputs to 0, instruction to 64'h0, done/busy/host_ready to 0.
REQ-036 rst deassertion mid-run yields IDLE; the interrupted run is not resumed.

Structure
REQ-037 Opcode constants, field bit positions and the FSM state encoding live in the shared package shared with the array controller.
REQ-038 One sub-module, instr_pack: combinational packer of opcode/address/data into the 64-bit word.

Verification
REQ-039 n_inp=2, n_wt=1, compute_len=3, i_mode_req=0, host always valid with data A,B,C -> sequence 00111; 00100@0 A; 00100@1 B; 00101@0 C; 3x00001; 00011@0..15; 00110@0..15; done pulse.
REQ-040 host_valid toggling 1/0 in LD_INP with n_inp=4 -> NOPs inserted in the gaps, addresses strictly 0,1,2,3, no word dropped or duplicated.
REQ-041 n_inp=0, n_wt=0, compute_len=0, i_mode_req=1 -> 00111 directly followed by DRAIN; no 00100/00101/00010 issued.
REQ-042 abort asserted in COMPUTE cycle 2 of 5 -> NOP next, busy low next cycle, no done; subsequent start runs a full sequence correctly.
REQ-043 rst=0 asserted during SEND address 7 -> instruction 0 immediately (asynchronous), IDLE after release.
REQ-044 start pulsed while busy -> ignored; run length and latched counts unchanged.
